// File: rtl/guvm_wb_resp_pkg.sv
// Shared types and constants for the GUVM wishbone instruction responder.
// Holds the responder FSM state type, default read-beat fill constants and the
// helper that assembles a 128-bit read beat.
package guvm_wb_resp_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StAck  = 2'd2
  } resp_state_e;

  localparam logic [95:0] DefaultFill    = 96'hF0081003F0081003F0081003;
  localparam logic [31:0] DefaultNopWord = 32'hF0081003;

  // Wide enough for ACK_LATENCY values 0..7.
  localparam int unsigned LatCntW = 3;

  function automatic logic [127:0] read_beat(logic [95:0] fill, logic [31:0] word);
    return {fill, word};
  endfunction

endpackage

// File: rtl/guvm_inst_fifo.sv
// Synchronous 32-bit instruction FIFO.
// Ports:
//   clk_i, rst_ni      clock, synchronous active-low reset
//   push_i, wdata_i    write request and data (ignored when full)
//   pop_i, rdata_o     read request (ignored when empty), head word
//   count_o            occupancy 0..Depth
//   empty_o, full_o    status flags
// A push into an empty FIFO is only visible from the next cycle (no bypass).
module guvm_inst_fifo #(
  parameter int unsigned Depth = 8,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  logic [31:0]     wdata_i,
  input  logic            pop_i,
  output logic [31:0]     rdata_o,
  output logic [CntW-1:0] count_o,
  output logic            empty_o,
  output logic            full_o
);

  logic [31:0]     mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            push_ok, pop_ok;

  always_comb begin
    empty_o = (count_q == '0);
    full_o  = (count_q == CntW'(Depth));
    push_ok = push_i & ~full_o;
    pop_ok  = pop_i & ~empty_o;

    // Depth is a power of two, so pointer overflow is the modulo wrap.
    wr_ptr_d = push_ok ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok ? rd_ptr_q + PtrW'(1) : rd_ptr_q;

    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/guvm_wb_inst_responder.sv
// Wishbone slave responder feeding the core's instruction/data port.
// Ports:
//   i_clk, i_rst_n                 clock, synchronous active-low reset
//   i_inst_valid/i_inst/o_inst_ready  driver push interface into the FIFO
//   i_wb_*                          core wishbone master outputs
//   o_wb_dat/o_wb_ack/o_wb_err      responses to the core (err tied low)
//   o_wr_valid/adr/sel/dat          one-cycle capture record of core writes
//   o_fifo_count, o_underflow       occupancy and sticky empty-read flag
// Each request is acked ACK_LATENCY+1 cycles after it is first presented.
// Reads return {FILL, head} and pop, or {FILL, NOP_WORD} when empty.
module guvm_wb_inst_responder
  import guvm_wb_resp_pkg::*;
#(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned ACK_LATENCY = 1,
  parameter logic [95:0] FILL        = DefaultFill,
  parameter logic [31:0] NOP_WORD    = DefaultNopWord
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_inst_valid,
  input  logic [31:0]                  i_inst,
  output logic                         o_inst_ready,
  input  logic [31:0]                  i_wb_adr,
  input  logic [15:0]                  i_wb_sel,
  input  logic                         i_wb_we,
  input  logic                         i_wb_cyc,
  input  logic                         i_wb_stb,
  input  logic [127:0]                 i_wb_dat,
  output logic [127:0]                 o_wb_dat,
  output logic                         o_wb_ack,
  output logic                         o_wb_err,
  output logic                         o_wr_valid,
  output logic [31:0]                  o_wr_adr,
  output logic [15:0]                  o_wr_sel,
  output logic [127:0]                 o_wr_dat,
  output logic [$clog2(DEPTH+1)-1:0]   o_fifo_count,
  output logic                         o_underflow
);

  localparam logic [LatCntW-1:0] AckLat = LatCntW'(ACK_LATENCY);

  resp_state_e        state_q, state_d;
  logic [LatCntW-1:0] lat_q, lat_d;
  logic [31:0]        adr_q, adr_d;
  logic [15:0]        sel_q, sel_d;
  logic               we_q, we_d;
  logic [127:0]       dat_q, dat_d;
  logic [127:0]       wb_dat_q, wb_dat_d;
  logic [31:0]        wr_adr_q, wr_adr_d;
  logic [15:0]        wr_sel_q, wr_sel_d;
  logic [127:0]       wr_dat_q, wr_dat_d;
  logic               underflow_q, underflow_d;

  logic        fifo_pop;
  logic [31:0] fifo_head;
  logic        fifo_empty;
  logic        fifo_full;
  logic        ack;
  logic        wr_valid;

  guvm_inst_fifo #(
    .Depth (DEPTH)
  ) u_fifo (
    .clk_i   (i_clk),
    .rst_ni  (i_rst_n),
    .push_i  (i_inst_valid),
    .wdata_i (i_inst),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .count_o (o_fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    adr_d       = adr_q;
    sel_d       = sel_q;
    we_d        = we_q;
    dat_d       = dat_q;
    wb_dat_d    = wb_dat_q;
    wr_adr_d    = wr_adr_q;
    wr_sel_d    = wr_sel_q;
    wr_dat_d    = wr_dat_q;
    underflow_d = underflow_q;
    fifo_pop    = 1'b0;
    ack         = 1'b0;
    wr_valid    = 1'b0;
    o_wb_dat    = wb_dat_q;
    o_wr_adr    = wr_adr_q;
    o_wr_sel    = wr_sel_q;
    o_wr_dat    = wr_dat_q;

    case (state_q)
      StIdle: begin
        if (i_wb_cyc && i_wb_stb) begin
          adr_d   = i_wb_adr;
          sel_d   = i_wb_sel;
          we_d    = i_wb_we;
          dat_d   = i_wb_dat;
          lat_d   = AckLat;
          state_d = (AckLat == '0) ? StAck : StWait;
        end
      end
      StWait: begin
        if (!i_wb_cyc) begin
          // Master gave up: drop the request without side effects.
          state_d = StIdle;
        end else begin
          lat_d = lat_q - LatCntW'(1);
          if (lat_q <= LatCntW'(1)) begin
            state_d = StAck;
          end
        end
      end
      StAck: begin
        state_d = StIdle;
        ack     = 1'b1;
        if (we_q) begin
          wr_valid = 1'b1;
          o_wr_adr = adr_q;
          o_wr_sel = sel_q;
          o_wr_dat = dat_q;
          wr_adr_d = adr_q;
          wr_sel_d = sel_q;
          wr_dat_d = dat_q;
        end else begin
          // Beat is shown combinationally in the ack cycle and held afterwards.
          o_wb_dat = read_beat(FILL, fifo_empty ? NOP_WORD : fifo_head);
          wb_dat_d = o_wb_dat;
          fifo_pop = ~fifo_empty;
          if (fifo_empty) begin
            underflow_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= StIdle;
      lat_q       <= '0;
      adr_q       <= '0;
      sel_q       <= '0;
      we_q        <= 1'b0;
      dat_q       <= '0;
      wb_dat_q    <= '0;
      wr_adr_q    <= '0;
      wr_sel_q    <= '0;
      wr_dat_q    <= '0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      adr_q       <= adr_d;
      sel_q       <= sel_d;
      we_q        <= we_d;
      dat_q       <= dat_d;
      wb_dat_q    <= wb_dat_d;
      wr_adr_q    <= wr_adr_d;
      wr_sel_q    <= wr_sel_d;
      wr_dat_q    <= wr_dat_d;
      underflow_q <= underflow_d;
    end
  end

  // An ack cycle coinciding with reset is discarded.
  assign o_wb_ack     = ack & i_rst_n;
  assign o_wr_valid   = wr_valid & i_rst_n;
  assign o_wb_err     = 1'b0;
  assign o_inst_ready = ~fifo_full;
  assign o_underflow  = underflow_q;

endmodule
